board_tx_seq: RTL and testbench

BOARD_TX_SEQ -- requirements
Module: board_tx_seq

---
 rtl/board_tx_seq_if.sv | 37 +++
 rtl/board_tx_seq.sv | 183 ++++++++++++++++++
 tb/tb_board_tx_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/board_tx_seq_if.sv
// ---------------------------------------------------------------------------
// board_tx_seq_if : frame-control, board-read and UART-side signals of
// board_tx_seq.
//   i_start        1  request one board frame
//   o_busy         1  frame in progress
//   o_done         1  end-of-frame pulse
//   o_sq_addr      6  board square read address
//   i_sq_data      8  ASCII piece for the addressed square
//   i_cursor_pos   6  cursor square
//   i_cursor_show  1  cursor blink phase (1 = visible)
//   o_tx_data      8  byte to UART transmitter
//   o_tx_stb       1  transmit strobe
//   i_tx_busy      1  UART transmitter busy
// master: the environment (board RAM, UART, controller); slave: the sequencer.
// ---------------------------------------------------------------------------
interface board_tx_seq_if;
  logic       i_start;
  logic       o_busy;
  logic       o_done;
  logic [5:0] o_sq_addr;
  logic [7:0] i_sq_data;
  logic [5:0] i_cursor_pos;
  logic       i_cursor_show;
  logic [7:0] o_tx_data;
  logic       o_tx_stb;
  logic       i_tx_busy;

  modport master (
    output i_start, i_sq_data, i_cursor_pos, i_cursor_show, i_tx_busy,
    input  o_busy, o_done, o_sq_addr, o_tx_data, o_tx_stb
  );

  modport slave (
    input  i_start, i_sq_data, i_cursor_pos, i_cursor_show, i_tx_busy,
    output o_busy, o_done, o_sq_addr, o_tx_data, o_tx_stb
  );
endinterface

// File: rtl/board_tx_seq.sv
// ---------------------------------------------------------------------------
// board_tx_seq : streams an 8x8 ASCII board to a UART transmitter, one byte
// per strobe, rows separated by LF CR, with the cursor square shown as '@'
// while the latched blink phase is visible.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        board_tx_seq_if.slave (frame control, board read, UART side)
// Build option:
//   BOARD_TX_HOME_EN  defined -> each frame is prefixed with ESC [ H
// ---------------------------------------------------------------------------
module board_tx_seq (
  input  logic           clk,
  input  logic           rst,
  board_tx_seq_if.slave  bus
);

`ifdef BOARD_TX_HOME_EN
  localparam int unsigned PFX_LEN = 3;
`else
  localparam int unsigned PFX_LEN = 0;
`endif
  localparam int unsigned FRAME_LEN = PFX_LEN + 78;
  localparam logic [6:0]  LAST_IDX  = 7'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef BOARD_TX_HOME_EN
    S_PRE,
`endif
    S_FETCH,
    S_SEND,
    S_SETTLE,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {K_SQ, K_LF, K_CR, K_PFX} kind_e;

  state_e     state_q;
  logic [6:0] cnt_q;       // byte index within the frame
  logic [5:0] sq_q;        // square index of the current/next square byte
  logic [5:0] cur_q;
  logic       show_q;
  logic       wait_q;      // second FETCH cycle: read data settling
  logic       busy_q;
  logic       done_q;
  logic       stb_q;
  logic [7:0] data_q;
  logic [5:0] addr_q;

  kind_e      kind_cur_c;
  kind_e      kind_nxt_c;
  logic [6:0] cnt_nxt_c;
  logic [7:0] tx_data_d;

  // Classify a frame byte index: prefix, square, LF or CR.
  function automatic kind_e byte_kind(input logic [6:0] idx);
    kind_e      k;
    logic [6:0] body;
    logic [3:0] col;
    k    = K_SQ;
    body = idx;
`ifdef BOARD_TX_HOME_EN
    if (idx < 7'd3) k = K_PFX;
    body = 7'(idx - 7'd3);
`endif
    col = 4'(body % 7'd10);
    if (k != K_PFX) begin
      if (col == 4'd8)      k = K_LF;
      else if (col == 4'd9) k = K_CR;
      else                  k = K_SQ;
    end
    return k;
  endfunction

  assign cnt_nxt_c  = 7'(cnt_q + 7'd1);
  assign kind_cur_c = byte_kind(cnt_q);
  assign kind_nxt_c = byte_kind(cnt_nxt_c);

  // Byte to transmit for the current index.
  always_comb begin
    tx_data_d = bus.i_sq_data;
    case (kind_cur_c)
      K_SQ:  if (show_q && (sq_q == cur_q)) tx_data_d = 8'h40;
      K_LF:  tx_data_d = 8'h0A;
      K_CR:  tx_data_d = 8'h0D;
      K_PFX: begin
`ifdef BOARD_TX_HOME_EN
        case (cnt_q[1:0])
          2'd0:    tx_data_d = 8'h1B;
          2'd1:    tx_data_d = 8'h5B;
          default: tx_data_d = 8'h48;
        endcase
`else
        tx_data_d = 8'h00;
`endif
      end
      default: tx_data_d = bus.i_sq_data;
    endcase
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      sq_q    <= 6'd0;
      cur_q   <= 6'd0;
      show_q  <= 1'b0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
      data_q  <= 8'h00;
      addr_q  <= 6'd0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            cur_q  <= bus.i_cursor_pos;
            show_q <= bus.i_cursor_show;
            cnt_q  <= 7'd0;
            sq_q   <= 6'd0;
            wait_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef BOARD_TX_HOME_EN
            state_q <= S_PRE;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef BOARD_TX_HOME_EN
        S_PRE: state_q <= S_SEND;
`endif
        // Address goes out in the first cycle; data is used once SEND strobes,
        // and the address is held so the read data stays stable meanwhile.
        S_FETCH: begin
          if (!wait_q) begin
            addr_q <= sq_q;
            wait_q <= 1'b1;
          end else begin
            wait_q  <= 1'b0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (!bus.i_tx_busy) begin
            data_q  <= tx_data_d;
            stb_q   <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        // One dead cycle so the UART can raise busy before the next byte.
        S_SETTLE: begin
          if ((kind_cur_c == K_SQ) && (sq_q != 6'd63)) sq_q <= 6'(sq_q + 6'd1);
          if (cnt_q == LAST_IDX) begin
            state_q <= S_DRAIN;
          end else begin
            cnt_q   <= cnt_nxt_c;
            state_q <= (kind_nxt_c == K_SQ) ? S_FETCH : S_SEND;
          end
        end
        S_DRAIN: begin
          if (!bus.i_tx_busy) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_sq_addr = addr_q;
  assign bus.o_tx_data = data_q;
  assign bus.o_tx_stb  = stb_q;

endmodule

// File: tb/tb_board_tx_seq.sv
// ---------------------------------------------------------------------------
// tb_board_tx_seq : scoreboard bench for board_tx_seq. Expected frames are
// built from the board contents and cursor at start time; a monitor pops and
// compares every strobed byte. Board RAM and UART busy are modelled here.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_board_tx_seq;
`ifdef BOARD_TX_HOME_EN
  localparam int PFX = 3;
`else
  localparam int PFX = 0;
`endif
  localparam int LEN = PFX + 78;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_tx_seq_if bus ();
  board_tx_seq dut (.clk(clk), .rst(rst), .bus(bus));

  // Board RAM: registered read
  logic [7:0] board [64];
  always @(posedge clk) bus.i_sq_data <= board[bus.o_sq_addr];

  // UART: busy for busy_len cycles after each strobe
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (bus.o_tx_stb)     busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.i_tx_busy = (busy_cnt != 0);

  logic [7:0] exp_q [$];
  logic [7:0] got [128];
  logic [7:0] mon_e;
  int n_vec = 0, n_err = 0;
  int frame_stb = 0, done_cnt = 0, cyc = 0, last_stb = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe is checked against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.o_tx_stb) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_byte", int'(bus.o_tx_data), int'(mon_e));
      end
      check("stb_while_busy", int'(bus.i_tx_busy), 0);
      if (frame_stb > 0)
        check("stb_spacing", int'((cyc - last_stb) >= ((busy_len > 0) ? busy_len + 1 : 2)), 1);
      if (frame_stb < 128) got[frame_stb] = bus.o_tx_data;
      frame_stb++;
      last_stb = cyc;
    end
    if (!rst && bus.o_done) begin
      done_cnt++;
      check("done_busy_low", int'(bus.o_busy), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: prefix, then 8 rows of 8 squares, LF CR between rows
  task automatic build_expect(input logic [5:0] cur, input logic show);
`ifdef BOARD_TX_HOME_EN
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h48);
`endif
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int sq;
        sq = r * 8 + c;
        exp_q.push_back((show && sq == int'(cur)) ? 8'h40 : board[sq]);
      end
      if (r < 7) begin
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
      end
    end
  endtask

  task automatic start_frame(input logic [5:0] cur, input logic show);
    build_expect(cur, show);
    frame_stb = 0;
    done_cnt  = 0;
    bus.i_cursor_pos  = cur;
    bus.i_cursor_show = show;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_strobes(input int k);
    int n = 0;
    while (frame_stb < k && n < 3000) begin
      tick();
      n++;
    end
    check("strobe_wait_timeout", int'(frame_stb >= k), 1);
  endtask

  task automatic wait_done(input bit scramble);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      if (scramble) begin
        bus.i_cursor_pos  = 6'($urandom_range(0, 63));
        bus.i_cursor_show = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    check("done_timeout", int'(done_cnt > 0), 1);
    repeat (30) tick();
    check("strobe_count", frame_stb, LEN);
    check("done_once", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic load_chess();
    string back_b, back_w;
    back_b = "rnbqkbnr";
    back_w = "RNBQKBNR";
    for (int i = 0; i < 64; i++) board[i] = 8'h2E;
    for (int i = 0; i < 8; i++) begin
      board[i]      = back_b[i];
      board[8 + i]  = 8'h70;
      board[48 + i] = 8'h50;
      board[56 + i] = back_w[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stb"},  int'(bus.o_tx_stb), 0);
    check({tag, "_busy"}, int'(bus.o_busy), 0);
    check({tag, "_done"}, int'(bus.o_done), 0);
    check({tag, "_addr"}, int'(bus.o_sq_addr), 0);
    check({tag, "_data"}, int'(bus.o_tx_data), 0);
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_cursor_pos = 6'd0;
    bus.i_cursor_show = 1'b0;
    load_chess();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Idle-UART chess frame
    start_frame(6'd0, 1'b0);
    wait_done(1'b0);
`ifdef BOARD_TX_HOME_EN
    check("prefix0", int'(got[0]), 'h1B);
    check("prefix1", int'(got[1]), 'h5B);
    check("prefix2", int'(got[2]), 'h48);
`endif
    check("first_square", int'(got[PFX]), 'h72);
    check("row0_lf", int'(got[PFX + 8]), 'h0A);
    check("row0_cr", int'(got[PFX + 9]), 'h0D);
    check("last_square", int'(got[LEN - 1]), 'h52);

    // Cursor visible / hidden on square 12
    start_frame(6'd12, 1'b1);
    wait_done(1'b1);
    check("cursor_shown", int'(got[PFX + 14]), 'h40);
    start_frame(6'd12, 1'b0);
    wait_done(1'b1);
    check("cursor_hidden", int'(got[PFX + 14]), 'h70);

    // Busy stretching
    busy_len = 10;
    start_frame(6'd63, 1'b1);
    wait_done(1'b0);
    busy_len = 0;

    // Second start mid-frame is ignored
    start_frame(6'd5, 1'b1);
    wait_strobes(PFX + 20);
    bus.i_cursor_pos = 6'd1;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_done(1'b0);

    // Reset mid-frame
    start_frame(6'd0, 1'b0);
    wait_strobes(PFX + 40);
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b0;
    exp_q.delete();
    snap = frame_stb;
    repeat (200) tick();
    check("no_strobe_after_reset", frame_stb, snap);
    start_frame(6'd9, 1'b1);
    wait_done(1'b0);

    // Random boards, cursors and UART latencies
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 64; i++) board[i] = 8'($urandom_range(33, 126));
      busy_len = $urandom_range(0, 4);
      start_frame(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      wait_done(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
